mc_control_unit: RTL
====================

# mc_control_unit

Sequencing controller for the multi-cycle MIPS-subset CPU. A five-state FSM advances each instruction through fetch, decode, execute, memory and write-back. It drives every write enable, mux select and ALU function code of the shared datapath, which holds the PC, IR, A/B/C registers, ALU and a unified memory. It exports its state on `q` so the top level can expose it for waveform debug.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clock` in 1: system clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26].
- `func` in 6: IR[5:0].
- `z` in 1: ALU zero flag; used in EXE only.
- `q` out 3: current state (IF=000, ID=001, EXE=010, MEM=011, WB=100).
- `wpc` out 1: PC write enable.
- `wir` out 1: IR write enable.
- `wmem` out 1: memory write enable.
- `wreg` out 1: register-file write enable.
- `iord` out 1: memory address select, 0=PC, 1=C.
- `regrt` out 1: destination select, 1=rt, 0=rd.
- `m2reg` out 1: write-back data select, 1=memory data, 0=C.
- `jal` out 1: destination forced to r31, write data = PC.
- `shift` out 1: ALU A operand = sa.
- `sext` out 1: sign-extend imm16, 0 = zero-extend.
- `alusrca` out 1: ALU A select, 0=PC, 1=A.
- `alusrcb` out 2: ALU B select, 00=B, 01=4, 10=ext imm, 11=ext imm<<2.
- `pcsource` out 2: next-PC select, 00=ALU, 01=C (branch target), 10=A (jr), 11=jump target.
- `aluc` out 4: ALU function.
- `inst_done` out 1: high during the final cycle of each instruction.

## Operation
- Supported instructions: add, sub, and, or, xor, sll, srl, sra, jr (R-type, op=000000); addi, andi, ori, xori, lw, sw, beq, bne, lui; j, jal.
- Any other op/func is a NOP. The FSM returns ID→IF with `inst_done`=1 and no register or memory write.
- `aluc` encodings: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111. The x bit is driven 0.
- IF: `wpc`=`wir`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluc`=add, `pcsource`=00. Next state ID.
- ID: `alusrca`=0, `alusrcb`=11, `sext`=1, `aluc`=add; this latches the branch target into C.
  - j: `wpc`=1, `pcsource`=11, then IF.
  - jal: additionally `wreg`=`jal`=1. PC already holds PC+4 and is the written value.
  - jr: `wpc`=1, `pcsource`=10, then IF.
  - All other instructions go to EXE.
- EXE:
  - beq/bne: `alusrca`=1, `alusrcb`=00, `aluc`=sub. `wpc`=1 with `pcsource`=01 iff (beq&z)|(bne&~z). Then IF.
  - lw/sw: `alusrca`=1, `alusrcb`=10, `sext`=1, `aluc`=add, then MEM.
  - R-type ALU ops: `alusrcb`=00. Shifts set `shift`=1; others set `alusrca`=1.
  - I-type ALU ops: `alusrcb`=10; `sext`=1 for addi only.
  - R-type and I-type ALU ops then go to WB.
- MEM: `iord`=1. sw: `wmem`=1, then IF. lw: go to WB.
- WB: `wreg`=1; `m2reg`=1 for lw; `regrt`=1 for I-type. Then IF.
- `inst_done`=1 in the terminating cycle: ID for j/jal/jr/NOP, EXE for branches, MEM for sw, WB otherwise.
- Outputs not listed in a state are 0.

## Timing
- State register is asynchronous-reset to IF. All outputs are combinational from state, `op`, `func` and `z`.
- While `resetn`=0: `q`=000 and `wpc`=`wir`=`wmem`=`wreg`=`inst_done`=0. Write enables are gated by `resetn`, so a mid-instruction reset aborts with no partial write.
- The first fetch occurs on the first rising edge after `resetn` rises.
- CPI: j/jr/jal/NOP 2; beq/bne 3; sw 4; R/I ALU 4; lw 5.
- `op`/`func` are sampled only in ID, EXE, MEM and WB, when IR is stable. In IF they are don't-care.
- `z` is sampled only in EXE of a branch.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings;
  - opcode and func constants;
  - `aluc` and `alusrcb`/`pcsource` select constants.
- Sub-module `mc_inst_decode` is combinational. It maps `op`/`func` to one-hot instruction flags plus class flags (`is_rtype`, `is_itype_alu`, `is_branch`, `is_mem`, `is_jump`).
- The FSM and output logic live in `mc_control_unit`.

## Test plan
- Reset held 3 cycles, then released → `q`=000 with all enables 0 during reset; `q`=000→001 on the following edges, with `wpc`=`wir`=1 in the IF cycle.
- add ($3=$1+$2, func 100000) → `q` sequence 000,001,010,100,000; in WB `wreg`=1, `regrt`=0, `m2reg`=0; `aluc`=0000 in EXE; `inst_done` only in WB.
- lw then sw → lw: `q` 000,001,010,011,100, with `iord`=1 in MEM and `m2reg`=`regrt`=1 in WB. sw: `wmem`=1 only in MEM, ending in 4 cycles.
- beq with z=1, then with z=0 → first: `wpc`=1 and `pcsource`=01 in EXE. Second: `wpc`=0 in EXE. Both return to IF after 3 cycles.
- j, jal, jr → each is 2 cycles, with `pcsource` 11/11/10 in ID. jal additionally asserts `wreg`=`jal`=1.
- Undefined op 111111, then reset asserted mid-EXE of an addi → the undefined op gives a 2-cycle NOP with no writes. After the reset, `q`=000 immediately (asynchronous), with no `wreg` pulse.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// function codes, ALU controls, mux selects and the decoded-instruction record.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'b000,
    ST_ID  = 3'b001,
    ST_EXE = 3'b010,
    ST_MEM = 3'b011,
    ST_WB  = 3'b100
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] SELB_B    = 2'b00;
  localparam logic [1:0] SELB_4    = 2'b01;
  localparam logic [1:0] SELB_IMM  = 2'b10;
  localparam logic [1:0] SELB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_C    = 2'b01;
  localparam logic [1:0] PCS_A    = 2'b10;
  localparam logic [1:0] PCS_JUMP = 2'b11;

  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw;
    logic i_beq, i_bne, i_j, i_jal;
    logic is_rtype, is_itype_alu, is_branch, is_mem, is_jump;
  } inst_t;

  // ALU function for the register/immediate ALU instructions executed in EXE.
  function automatic logic [3:0] alu_fn(inst_t d);
    logic [3:0] f;
    f = ALUC_ADD;
    if (d.i_sub)                f = ALUC_SUB;
    if (d.i_and  || d.i_andi)   f = ALUC_AND;
    if (d.i_or   || d.i_ori)    f = ALUC_OR;
    if (d.i_xor  || d.i_xori)   f = ALUC_XOR;
    if (d.i_lui)                f = ALUC_LUI;
    if (d.i_sll)                f = ALUC_SLL;
    if (d.i_srl)                f = ALUC_SRL;
    if (d.i_sra)                f = ALUC_SRA;
    if (d.i_add  || d.i_addi)   f = ALUC_ADD;
    return f;
  endfunction

endpackage

// File: rtl/mc_inst_decode.sv
// Combinational opcode/func decoder: one-hot instruction flags plus class flags.
module mc_inst_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output inst_t      inst_o
);

  logic rtype;
  assign rtype = (op_i == OP_RTYPE);

  always_comb begin
    inst_o        = '0;
    inst_o.i_add  = rtype && (func_i == FN_ADD);
    inst_o.i_sub  = rtype && (func_i == FN_SUB);
    inst_o.i_and  = rtype && (func_i == FN_AND);
    inst_o.i_or   = rtype && (func_i == FN_OR);
    inst_o.i_xor  = rtype && (func_i == FN_XOR);
    inst_o.i_sll  = rtype && (func_i == FN_SLL);
    inst_o.i_srl  = rtype && (func_i == FN_SRL);
    inst_o.i_sra  = rtype && (func_i == FN_SRA);
    inst_o.i_jr   = rtype && (func_i == FN_JR);
    inst_o.i_addi = (op_i == OP_ADDI);
    inst_o.i_andi = (op_i == OP_ANDI);
    inst_o.i_ori  = (op_i == OP_ORI);
    inst_o.i_xori = (op_i == OP_XORI);
    inst_o.i_lui  = (op_i == OP_LUI);
    inst_o.i_lw   = (op_i == OP_LW);
    inst_o.i_sw   = (op_i == OP_SW);
    inst_o.i_beq  = (op_i == OP_BEQ);
    inst_o.i_bne  = (op_i == OP_BNE);
    inst_o.i_j    = (op_i == OP_J);
    inst_o.i_jal  = (op_i == OP_JAL);

    // jr is R-format but leaves from ID, so it is a jump rather than an ALU op.
    inst_o.is_rtype     = inst_o.i_add | inst_o.i_sub | inst_o.i_and | inst_o.i_or |
                          inst_o.i_xor | inst_o.i_sll | inst_o.i_srl | inst_o.i_sra;
    inst_o.is_itype_alu = inst_o.i_addi | inst_o.i_andi | inst_o.i_ori |
                          inst_o.i_xori | inst_o.i_lui;
    inst_o.is_branch    = inst_o.i_beq | inst_o.i_bne;
    inst_o.is_mem       = inst_o.i_lw | inst_o.i_sw;
    inst_o.is_jump      = inst_o.i_j | inst_o.i_jal | inst_o.i_jr;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Five-state sequencing FSM of the multi-cycle CPU; drives every datapath
// enable, mux select and ALU function combinationally from state and IR fields.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic [2:0] q,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       sext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [3:0] aluc,
  output logic       inst_done
);

  state_e state_q, state_d;
  inst_t  dec;
  logic   wpc_c, wir_c, wmem_c, wreg_c, done_c;
  logic   taken;

  mc_inst_decode u_decode (
    .op_i   (op),
    .func_i (func),
    .inst_o (dec)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IF;
    else         state_q <= state_d;
  end

  assign taken = (dec.i_beq & z) | (dec.i_bne & ~z);

  always_comb begin
    state_d  = state_q;
    wpc_c    = 1'b0;
    wir_c    = 1'b0;
    wmem_c   = 1'b0;
    wreg_c   = 1'b0;
    done_c   = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SELB_B;
    pcsource = PCS_ALU;
    aluc     = ALUC_ADD;
    case (state_q)
      ST_IF: begin
        wpc_c   = 1'b1;
        wir_c   = 1'b1;
        alusrcb = SELB_4;
        state_d = ST_ID;
      end
      ST_ID: begin
        // PC already holds PC+4, so this add leaves the branch target in C.
        alusrcb = SELB_IMM2;
        sext    = 1'b1;
        if (dec.is_jump) begin
          wpc_c    = 1'b1;
          pcsource = dec.i_jr ? PCS_A : PCS_JUMP;
          wreg_c   = dec.i_jal;
          jal      = dec.i_jal;
          done_c   = 1'b1;
          state_d  = ST_IF;
        end else if (dec.is_rtype | dec.is_itype_alu | dec.is_branch | dec.is_mem) begin
          state_d = ST_EXE;
        end else begin
          done_c  = 1'b1;
          state_d = ST_IF;
        end
      end
      ST_EXE: begin
        if (dec.is_branch) begin
          alusrca  = 1'b1;
          aluc     = ALUC_SUB;
          wpc_c    = taken;
          pcsource = taken ? PCS_C : PCS_ALU;
          done_c   = 1'b1;
          state_d  = ST_IF;
        end else if (dec.is_mem) begin
          alusrca = 1'b1;
          alusrcb = SELB_IMM;
          sext    = 1'b1;
          state_d = ST_MEM;
        end else if (dec.is_rtype) begin
          shift   = dec.i_sll | dec.i_srl | dec.i_sra;
          alusrca = ~shift;
          aluc    = alu_fn(dec);
          state_d = ST_WB;
        end else if (dec.is_itype_alu) begin
          alusrca = 1'b1;
          alusrcb = SELB_IMM;
          sext    = dec.i_addi;
          aluc    = alu_fn(dec);
          state_d = ST_WB;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        iord = 1'b1;
        if (dec.i_sw) begin
          wmem_c  = 1'b1;
          done_c  = 1'b1;
          state_d = ST_IF;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        wreg_c  = 1'b1;
        m2reg   = dec.i_lw;
        regrt   = dec.i_lw | dec.is_itype_alu;
        done_c  = 1'b1;
        state_d = ST_IF;
      end
      default: state_d = ST_IF;
    endcase
  end

  // Reset masks every write so an interrupted instruction leaves no partial update.
  assign wpc       = wpc_c  & resetn;
  assign wir       = wir_c  & resetn;
  assign wmem      = wmem_c & resetn;
  assign wreg      = wreg_c & resetn;
  assign inst_done = done_c & resetn;
  assign q         = state_q;

endmodule
